// File: rtl/flag_unit_pkg.sv
// Shared definitions for the condition-flag unit: flag bit positions,
// flag vector width, hazard FSM state encoding and a packing helper.
package flag_unit_pkg;

  localparam int FLAG_W = 4;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef logic [FLAG_W-1:0] flags_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fsm_state_e;

  // Build a flag vector in the fixed {N,Z,V,C} order.
  function automatic flags_t pack_flags(input logic n, input logic z,
                                        input logic v, input logic c);
    flags_t f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    return f;
  endfunction

endpackage

// File: rtl/flag_unit_if.sv
// Bundle between the EX ALU / ID branch logic and the flag unit.
// Handshake: there is no valid/ready pair here. ex_valid qualifies the EX
// flag inputs for the current cycle only; flagStall is the sole back-pressure
// signal and, when high, the ID stage must hold its instruction for one more
// cycle (the flag unit never waits on the consumer).
interface flag_unit_if;
  import flag_unit_pkg::*;

  logic   ex_valid;
  logic   ex_setFlags;
  logic   ex_negative;
  logic   ex_overflow;
  logic   ex_carry_out;
  logic   ex_zero;
  logic   id_condBr;
  logic   flush;
  logic   negative;
  logic   overflow;
  logic   carry_out;
  logic   zero;
  logic   flagStall;
  flags_t flags_q;

  // Pipeline side: drives EX/ID status, consumes flags and stall.
  modport master (
    output ex_valid, ex_setFlags, ex_negative, ex_overflow, ex_carry_out,
           ex_zero, id_condBr, flush,
    input  negative, overflow, carry_out, zero, flagStall, flags_q
  );

  // Flag unit side.
  modport slave (
    input  ex_valid, ex_setFlags, ex_negative, ex_overflow, ex_carry_out,
           ex_zero, id_condBr, flush,
    output negative, overflow, carry_out, zero, flagStall, flags_q
  );

endinterface

// File: rtl/flag_unit_flag_reg.sv
// Architectural NZVC register: synchronous reset to a configurable value,
// loads on write enable, otherwise holds.
module flag_reg
  import flag_unit_pkg::*;
#(
  parameter flags_t RESET_FLAGS = '0
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   we,
  input  flags_t wdata,
  output flags_t data_o
);

  flags_t data_q;
  flags_t data_d;

  // Next value: load new flags when written, else hold.
  always_comb begin
    data_d = data_q;
    if (we) begin
      data_d = wdata;
    end
  end

  // Register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= RESET_FLAGS;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/flag_unit.sv
// Condition-flag producer: holds NZVC, and either forwards in-flight EX flags
// to the ID branch logic (FWD_EX=1) or stalls ID for one cycle (FWD_EX=0) so
// a conditional branch never sees stale flags.
module flag_unit
  import flag_unit_pkg::*;
#(
  parameter bit     FWD_EX      = 1'b1,
  parameter flags_t RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  flag_unit_if.slave  fif,
  output fsm_state_e  state_o
);

  fsm_state_e state_q;
  fsm_state_e state_d;
  flags_t     ex_flags;
  flags_t     reg_flags;
  flags_t     out_flags;
  logic       wr;
  logic       stall;

  assign ex_flags = pack_flags(fif.ex_negative, fif.ex_zero,
                               fif.ex_overflow, fif.ex_carry_out);

  // A flush kills the EX instruction, so it may neither write nor forward.
  assign wr = fif.ex_valid & fif.ex_setFlags & ~fif.flush;

  flag_reg #(
    .RESET_FLAGS (RESET_FLAGS)
  ) u_flag_reg (
    .clk    (clk),
    .reset  (reset),
    .we     (wr),
    .wdata  (ex_flags),
    .data_o (reg_flags)
  );

  // Flag source for the branch logic: live EX flags when forwarding a write.
  always_comb begin
    out_flags = reg_flags;
    if (FWD_EX && wr) begin
      out_flags = ex_flags;
    end
  end

  // Hazard FSM: one stall cycle while a flag-setter in EX meets a B.cond in
  // ID; in WAIT the new flags are architectural, so the branch resolves.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    if (!FWD_EX) begin
      case (state_q)
        ST_IDLE: begin
          if (fif.id_condBr && wr) begin
            stall   = 1'b1;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State register; reset also abandons any pending WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign fif.negative  = out_flags[FLAG_N];
  assign fif.zero      = out_flags[FLAG_Z];
  assign fif.overflow  = out_flags[FLAG_V];
  assign fif.carry_out = out_flags[FLAG_C];
  assign fif.flagStall = stall;
  assign fif.flags_q   = reg_flags;
  assign state_o       = state_q;

endmodule

// File: tb/tb_flag_unit.sv
// Bench for flag_unit: a forwarding instance and a stalling instance share
// the same stimulus. A directed vector table runs first, then random cycles
// checked against a cycle-level behavioural model.
module tb_flag_unit;
  import flag_unit_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  fsm_state_e state_a;
  fsm_state_e state_b;
  int         total = 0;
  int         bad   = 0;

  flag_unit_if if_a ();
  flag_unit_if if_b ();

  flag_unit #(.FWD_EX(1'b1), .RESET_FLAGS(4'b0000)) dut_a (
    .clk(clk), .reset(reset), .fif(if_a), .state_o(state_a)
  );
  flag_unit #(.FWD_EX(1'b0), .RESET_FLAGS(4'b0000)) dut_b (
    .clk(clk), .reset(reset), .fif(if_b), .state_o(state_b)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v;
    logic       s;
    logic [3:0] f;
    logic       br;
    logic       fl;
    logic [3:0] a_out;
    logic [3:0] a_q;
    logic [3:0] b_out;
    logic       b_stall;
    logic [3:0] b_q;
  } vec_t;

  vec_t vecs[19];

  // Behavioural model state
  logic [3:0] m_q;
  logic       m_prev_stall;

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rst, input logic v, input logic s,
                       input logic [3:0] f, input logic br, input logic fl);
    reset             = rst;
    if_a.ex_valid     = v;   if_b.ex_valid     = v;
    if_a.ex_setFlags  = s;   if_b.ex_setFlags  = s;
    if_a.ex_negative  = f[3]; if_b.ex_negative  = f[3];
    if_a.ex_zero      = f[2]; if_b.ex_zero      = f[2];
    if_a.ex_overflow  = f[1]; if_b.ex_overflow  = f[1];
    if_a.ex_carry_out = f[0]; if_b.ex_carry_out = f[0];
    if_a.id_condBr    = br;  if_b.id_condBr    = br;
    if_a.flush        = fl;  if_b.flush        = fl;
  endtask

  function automatic logic [3:0] out_a();
    return {if_a.negative, if_a.zero, if_a.overflow, if_a.carry_out};
  endfunction

  function automatic logic [3:0] out_b();
    return {if_b.negative, if_b.zero, if_b.overflow, if_b.carry_out};
  endfunction

  // Advance the model across a clock edge with the current inputs.
  task automatic model_edge(input logic rst, input logic v, input logic s,
                            input logic [3:0] f, input logic br, input logic fl);
    logic wr;
    logic stall;
    wr    = v & s & ~fl;
    stall = br & wr & ~m_prev_stall;
    if (rst) begin
      m_q          = 4'b0000;
      m_prev_stall = 1'b0;
    end else begin
      if (wr) m_q = f;
      m_prev_stall = stall;
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic v, input logic s,
                              input logic [3:0] f, input logic br,
                              input logic fl, input logic [3:0] a_out,
                              input logic [3:0] a_q, input logic [3:0] b_out,
                              input logic b_stall, input logic [3:0] b_q);
    vec_t r;
    r.rst = rst; r.v = v; r.s = s; r.f = f; r.br = br; r.fl = fl;
    r.a_out = a_out; r.a_q = a_q; r.b_out = b_out; r.b_stall = b_stall;
    r.b_q = b_q;
    return r;
  endfunction

  initial begin
    //           rst v  s  f        br fl a_out    a_q      b_out    stl b_q
    vecs[0]  = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000); // reset state
    vecs[1]  = mk(0, 1, 1, 4'b1001, 0, 0, 4'b1001, 4'b0000, 4'b0000, 0, 4'b0000); // write, forwarded
    vecs[2]  = mk(0, 1, 0, 4'b0000, 0, 0, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001); // no setFlags
    vecs[3]  = mk(0, 0, 0, 4'b0000, 0, 0, 4'b1001, 4'b1001, 4'b1001, 0, 4'b1001); // hold
    vecs[4]  = mk(0, 1, 1, 4'b0100, 1, 0, 4'b0100, 4'b1001, 4'b1001, 1, 4'b1001); // hazard Z
    vecs[5]  = mk(0, 0, 0, 4'b0000, 1, 0, 4'b0100, 4'b0100, 4'b0100, 0, 4'b0100); // WAIT
    vecs[6]  = mk(0, 1, 1, 4'b1000, 1, 0, 4'b1000, 4'b0100, 4'b0100, 1, 4'b0100); // hazard N
    vecs[7]  = mk(0, 1, 1, 4'b1000, 1, 0, 4'b1000, 4'b1000, 4'b1000, 0, 4'b1000); // held repeat
    vecs[8]  = mk(0, 1, 1, 4'b0011, 1, 1, 4'b1000, 4'b1000, 4'b1000, 0, 4'b1000); // flush hazard
    vecs[9]  = mk(0, 0, 0, 4'b0000, 0, 0, 4'b1000, 4'b1000, 4'b1000, 0, 4'b1000); // unchanged
    vecs[10] = mk(0, 1, 1, 4'b0001, 1, 0, 4'b0001, 4'b1000, 4'b1000, 1, 4'b1000); // hazard C
    vecs[11] = mk(0, 1, 1, 4'b0110, 1, 1, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0001); // flush in WAIT
    vecs[12] = mk(0, 0, 0, 4'b0000, 1, 0, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0001); // idle branch
    vecs[13] = mk(0, 0, 1, 4'b1111, 1, 0, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0001); // bubble
    vecs[14] = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 4'b0001); // unchanged
    vecs[15] = mk(0, 1, 1, 4'b1111, 1, 0, 4'b1111, 4'b0001, 4'b0001, 1, 4'b0001); // hazard
    vecs[16] = mk(1, 1, 1, 4'b0110, 1, 0, 4'b0110, 4'b1111, 4'b1111, 0, 4'b1111); // reset in WAIT
    vecs[17] = mk(0, 0, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000); // write dropped
    vecs[18] = mk(0, 1, 1, 4'b1010, 1, 0, 4'b1010, 4'b0000, 4'b0000, 1, 4'b0000); // IDLE again

    // Reset block
    apply(1, 0, 0, 4'b0000, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    m_q          = 4'b0000;
    m_prev_stall = 1'b0;

    // Directed table
    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].f, vecs[i].br, vecs[i].fl);
      @(negedge clk);
      check($sformatf("vec%0d_a_out", i), out_a(), vecs[i].a_out);
      check($sformatf("vec%0d_a_q", i), if_a.flags_q, vecs[i].a_q);
      check($sformatf("vec%0d_a_stall", i), {3'b000, if_a.flagStall}, 4'b0000);
      check($sformatf("vec%0d_b_out", i), out_b(), vecs[i].b_out);
      check($sformatf("vec%0d_b_stall", i), {3'b000, if_b.flagStall},
            {3'b000, vecs[i].b_stall});
      check($sformatf("vec%0d_b_q", i), if_b.flags_q, vecs[i].b_q);
      model_edge(vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].f, vecs[i].br,
                 vecs[i].fl);
      @(posedge clk);
      #1;
    end

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      logic       rst, v, s, br, fl, wr, exp_stall;
      logic [3:0] f, exp_a;
      rst = ($urandom_range(0, 31) == 0);
      v   = ($urandom_range(0, 3) != 0);
      s   = ($urandom_range(0, 2) != 0);
      f   = 4'($urandom_range(0, 15));
      br  = ($urandom_range(0, 1) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      apply(rst, v, s, f, br, fl);
      @(negedge clk);
      wr        = v & s & ~fl;
      exp_a     = wr ? f : m_q;
      exp_stall = br & wr & ~m_prev_stall;
      check("rnd_a_out", out_a(), exp_a);
      check("rnd_a_q", if_a.flags_q, m_q);
      check("rnd_a_stall", {3'b000, if_a.flagStall}, 4'b0000);
      check("rnd_b_out", out_b(), m_q);
      check("rnd_b_stall", {3'b000, if_b.flagStall}, {3'b000, exp_stall});
      check("rnd_b_q", if_b.flags_q, m_q);
      model_edge(rst, v, s, f, br, fl);
      @(posedge clk);
      #1;
    end

    // Report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
